// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - XLEN / PC_WIDTH constants sizing the decoded packet
//   - imm_fmt_t immediate-format enum and decode_pkt_t packet struct
//   - opcode / funct3 / funct7 constants
//   - instruction encoder helpers (R/I/S/B/U/J)
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_fmt_t;

  // Major opcodes (full 7 bits, low two bits always 2'b11)
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_REG_IMM = 7'b0010011;
  localparam logic [6:0] OPC_REG_REG = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

  // ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // funct7 values overlap across opcodes, so they stay plain constants
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0]     reg_a;
    logic [XLEN-1:0]     reg_b;
    logic [XLEN-1:0]     imm;
    imm_fmt_t            imm_fmt;
    logic                rd_we;
    logic                illegal;
  } decode_pkt_t;

  function automatic logic [31:0] enc_r(input logic [6:0] funct7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] funct3,
                                        input logic [4:0] rd, input logic [6:0] opcode);
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] funct3, input logic [4:0] rd,
                                        input logic [6:0] opcode);
    return {imm, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] funct3);
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
  endfunction

  // imm[0] is implied zero and ignored
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] funct3);
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opcode);
    return {imm, rd, opcode};
  endfunction

  // imm[0] is implied zero and ignored
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: combinational immediate generator.
//   instr   in  32    raw instruction
//   imm     out XLEN  immediate, sign-extended from its format's top bit
//   imm_fmt out       format selected from the opcode (IMM_R when none)
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        imm_fmt
);

  // All formats fit in 32 bits; build them sign-extended to 32 first,
  // then the signed size cast extends further when XLEN > 32.
  logic signed [31:0] raw;

  always_comb begin
    raw     = '0;
    imm_fmt = IMM_R;
    case (instr[6:0])
      OPC_LOAD, OPC_REG_IMM, OPC_JALR: begin
        imm_fmt = IMM_I;
        raw     = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        raw     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B;
        raw     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_fmt = IMM_U;
        raw     = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_fmt = IMM_J;
        raw     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        imm_fmt = IMM_R;
        raw     = '0;
      end
    endcase
    imm = XLEN'(raw);
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I decode stage between fetch and execute.
//   clk, rst_n             clock, asynchronous active-low reset
//   flush_i                drop all buffered and incoming beats this cycle
//   if_valid_i/if_ready_o  fetch handshake; if_instr_i, if_pc_i payload
//   rf_rs*_addr_o          register-file read addresses (from if_instr_i)
//   rf_rs*_data_i          same-cycle register-file read data
//   ex_valid_o/ex_ready_i  execute handshake; ex_pkt_o decoded packet
// Decode is combinational on the fetch side; the result lands in a
// two-entry skid buffer (main = output register, skid = overflow).
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [31:0]         if_instr_i,
  input  logic [PC_WIDTH-1:0] if_pc_i,
  output logic [4:0]          rf_rs1_addr_o,
  output logic [4:0]          rf_rs2_addr_o,
  input  logic [XLEN-1:0]     rf_rs1_data_i,
  input  logic [XLEN-1:0]     rf_rs2_data_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output decode_pkt_t         ex_pkt_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  imm_fmt_t        imm_fmt;
  logic            writes_rd;
  logic            illegal;
  decode_pkt_t     dec_pkt;

  logic            main_valid;
  logic            skid_valid;
  decode_pkt_t     main_pkt;
  decode_pkt_t     skid_pkt;
  logic            accept;
  logic            issue;

  assign opcode = if_instr_i[6:0];
  assign rd     = if_instr_i[11:7];
  assign funct3 = if_instr_i[14:12];
  assign funct7 = if_instr_i[31:25];

  assign rf_rs1_addr_o = if_instr_i[19:15];
  assign rf_rs2_addr_o = if_instr_i[24:20];

  riscv_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr  (if_instr_i),
    .imm    (imm),
    .imm_fmt(imm_fmt)
  );

  always_comb begin
    writes_rd = 1'b0;
    illegal   = (if_instr_i[1:0] != 2'b11);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR: begin
        writes_rd = 1'b1;
        if (funct3 != F3_JALR) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end
      OPC_STORE: begin
        if (funct3 > 3'b010) illegal = 1'b1;
      end
      OPC_REG_IMM: begin
        writes_rd = 1'b1;
        // Only the shift-immediates carry a funct7 field
        if (funct3 == F3_SLL && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == F3_SRL_SRA && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
      end
      OPC_REG_REG: begin
        writes_rd = 1'b1;
        if (funct7 == F7_ALT) begin
          if (funct3 != F3_ADD_SUB && funct3 != F3_SRL_SRA) illegal = 1'b1;
        end else if (funct7 != F7_BASE) begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_pkt         = '0;
    dec_pkt.opcode  = opcode;
    dec_pkt.rd      = rd;
    dec_pkt.rs1     = if_instr_i[19:15];
    dec_pkt.rs2     = if_instr_i[24:20];
    dec_pkt.funct3  = funct3;
    dec_pkt.funct7  = funct7;
    dec_pkt.pc      = if_pc_i;
    dec_pkt.reg_a   = rf_rs1_data_i;
    dec_pkt.reg_b   = rf_rs2_data_i;
    dec_pkt.imm     = imm;
    dec_pkt.imm_fmt = imm_fmt;
    dec_pkt.rd_we   = writes_rd && (rd != 5'd0) && !illegal;
    dec_pkt.illegal = illegal;
  end

  // Ready depends only on the skid register, so ex_ready_i never
  // reaches if_ready_o combinationally.
  assign if_ready_o = !skid_valid;
  assign ex_valid_o = main_valid;
  assign ex_pkt_o   = main_pkt;

  assign accept = if_valid_i && if_ready_o;
  assign issue  = main_valid && ex_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pkt   <= '0;
      skid_pkt   <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || issue) begin
      // Main frees up: refill from skid first to keep FIFO order. A
      // full skid implies if_ready_o=0, so no new beat competes here.
      if (skid_valid) begin
        main_pkt   <= skid_pkt;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_pkt <= dec_pkt;
      end
    end else if (accept) begin
      skid_pkt   <= dec_pkt;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Parametrised RV32I instruction-decode pipeline stage between fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake, reads two register-file operands, generates the full sign-extended immediate for every format, flags illegal encodings, and registers the decoded packet into a two-entry skid buffer. The buffer gives full throughput under execute back-pressure. Flush support discards wrong-path instructions.

## Interface
- XLEN, 32: register/data width; immediates are sign-extended to XLEN.
- PC_WIDTH, 32: program-counter width.
- clk  in  1  stage clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- flush_i  in  1  discard all buffered and incoming instructions this cycle.
- if_valid_i  in  1  fetch presents an instruction.
- if_ready_o  out  1  stage can accept an instruction.
- if_instr_i  in  32  raw instruction.
- if_pc_i  in  PC_WIDTH  PC of the instruction.
- rf_rs1_addr_o / rf_rs2_addr_o  out  5  register-file read addresses, combinational from if_instr_i[19:15] / [24:20].
- rf_rs1_data_i / rf_rs2_data_i  in  XLEN  combinational read data, same cycle.
- ex_valid_o  out  1  decoded packet valid.
- ex_ready_i  in  1  execute accepts the packet.
- ex_pkt_o  out  decode_pkt_t  opcode, rd, rs1, rs2, funct3, funct7, pc, reg_a, reg_b, imm[XLEN-1:0], imm_fmt, rd_we, illegal.

## Operation
- Accept when if_valid_i && if_ready_o. Issue when ex_valid_o && ex_ready_i.
- Accepted instructions are decoded and registered. rs1/rs2 data are captured at acceptance. No forwarding or hazard detection is done here.
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
  - All formats are sign-extended from their top bit to XLEN.
- rd_we = 1 for REG_IMM, REG_REG, LOAD, JAL, JALR, LUI, AUIPC, only when rd != 0 and not illegal.
- illegal = 1 when any of the following holds:
  - instr[1:0] != 2'b11, or the opcode is unlisted.
  - REG_REG with funct7 other than 0x00/0x20, or funct7 0x20 with funct3 not ADD_SUB/SRL_SRA.
  - REG_IMM SLLI with funct7 != 0x00, or SRLI/SRAI with funct7 not 0x00/0x20.
  - JALR with funct3 != 0.
  - BRANCH with funct3 010/011.
  - LOAD with funct3 011/110/111.
  - STORE with funct3 > 010.
- Illegal instructions still propagate in order, with illegal=1 and rd_we=0.
- Skid buffer: a main (output) register plus a skid register.
  - An accepted beat goes to main when main is empty or issuing this cycle; otherwise it goes to skid.
  - When main issues and skid is full, skid moves to main.
  - if_ready_o = !skid_valid, registered, with no combinational path from ex_ready_i.
- Ordering is strictly FIFO. No beat is lost or duplicated.
- flush_i has priority over everything. At the next edge both valid bits clear, and any beat presented in the flush cycle is dropped, even if the handshake completed.

## Timing
- Latency is 1 cycle from acceptance to ex_valid_o. Throughput is 1 instr/cycle while ex_ready_i=1.
- Reset values:
  - ex_valid_o=0 and ex_pkt_o all-zero.
  - if_ready_o=1 (skid empty).
  - All registers clear asynchronously on rst_n low, including mid-transfer. The first acceptance is possible in the first cycle after rst_n deasserts.
- Full condition: main and skid both valid. if_ready_o=0 from the following cycle until an issue occurs.
- Simultaneous accept and issue with skid empty: main reloads with the new beat and ex_valid_o stays 1.
- rf_*_addr_o track if_instr_i combinationally, independent of the handshake.

## Structure
- The shared package riscv_pkg holds:
  - imm_fmt_t enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R).
  - decode_pkt_t struct, parameterised via XLEN/PC_WIDTH package constants.
  - Opcode, funct3 and funct7 constants; funct7 values are localparams, not an enum, because values overlap.
  - Encoder functions, with the B-type encoder taking a 13-bit immediate.
- One sub-module, riscv_imm_gen: a combinational instruction-to-(imm, imm_fmt) generator, reused by the benches' reference model.
- Decode and illegal checks are combinational in the top level. The skid buffer is in the top level.

## Test plan
- addi x1,x0,-1 (0xFFF00093) with ex_ready_i=1 → one cycle later: imm=0xFFFFFFFF, rd=1, rd_we=1, illegal=0, imm_fmt=IMM_I.
- beq x1,x2,-4 (0xFE208EE3) then jal x1,+2048 (0x001000EF) back-to-back → imm 0xFFFFFFFC then 0x00000800. rf_rs1_addr_o=1 and rf_rs2_addr_o=2 on the beq cycle; reg_a/reg_b equal the captured rf data.
- ex_ready_i=0 while three instructions are offered → two accepted, if_ready_o=0 from the cycle after the second. Release ex_ready_i → all three issue in order, none lost or duplicated.
- Both registers full, if_valid_i=1, flush_i=1 → next cycle ex_valid_o=0 and if_ready_o=1; the presented instruction never appears.
- 0x00000000, then 0x02000033 (funct7=0x01, REG_REG) → both issue with illegal=1 and rd_we=0.
- Assert rst_n low mid-stream with both registers valid → ex_valid_o=0 and ex_pkt_o=0 without waiting for a clock edge; if_ready_o=1.
